// File: rtl/lwe_pkg.sv
// Shared constants and arithmetic helpers for the LWE encrypt/multiply datapath.
//   mod_width : log2 of a power-of-two modulus, i.e. the register width it needs
//   mod_add   : ciphertext add, carries dropped (mod q)
//   mod_mul   : ciphertext multiply, high product bits dropped (mod q)
package lwe_pkg;

  function automatic int unsigned mod_width(input int unsigned modulus);
    return $clog2(modulus);
  endfunction

  localparam int unsigned PLAINTEXT_MODULUS  = 8;
  localparam int unsigned PLAINTEXT_WIDTH    = mod_width(PLAINTEXT_MODULUS);
  localparam int unsigned CIPHERTEXT_MODULUS = 64;
  localparam int unsigned CIPHERTEXT_WIDTH   = mod_width(CIPHERTEXT_MODULUS);
  localparam int unsigned DIMENSION          = 1;
  localparam int unsigned BIG_N              = 5;

  // Ciphertext entries per vector and product coefficients per result.
  localparam int unsigned CT_ROWS   = DIMENSION + 1;
  localparam int unsigned ACC_ROWS  = 2 * DIMENSION + 1;
  localparam int unsigned ROW_WIDTH = DIMENSION + 1;

  typedef logic [CIPHERTEXT_WIDTH-1:0] ct_t;

  function automatic ct_t mod_add(input ct_t a, input ct_t b);
    return CIPHERTEXT_WIDTH'(a + b);
  endfunction

  function automatic ct_t mod_mul(input ct_t a, input ct_t b);
    logic [2*CIPHERTEXT_WIDTH-1:0] full;
    full = (2*CIPHERTEXT_WIDTH)'(a) * (2*CIPHERTEXT_WIDTH)'(b);
    return CIPHERTEXT_WIDTH'(full);
  endfunction

endpackage

// File: rtl/lwe_encrypt_row.sv
// Encrypt engine: one ciphertext entry per cycle, 1-cycle latency.
//   plaintext_i    : message, added unscaled on row 0 only
//   publickey_i    : BIG_N flattened entries, entry i at [i*W +: W]
//   noise_select_i : subset bits, MSB selects entry 0
//   row_i          : index of the ciphertext entry being produced
//   ciphertext_o   : registered entry, sum mod 2^W
module lwe_encrypt_row #(
  parameter int unsigned BIG_N   = 5,
  parameter int unsigned W       = 6,
  parameter int unsigned PT_W    = 3,
  parameter int unsigned ROW_W   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PT_W-1:0]    plaintext_i,
  input  logic [BIG_N*W-1:0] publickey_i,
  input  logic [BIG_N-1:0]   noise_select_i,
  input  logic [ROW_W-1:0]   row_i,
  output logic [W-1:0]       ciphertext_o
);

  logic [W-1:0] sum_c;
  logic [W-1:0] ciphertext_d;
  logic [W-1:0] ciphertext_q;

  // Subset sum; selection bits are reversed relative to entry order.
  always_comb begin
    sum_c = '0;
    for (int unsigned i = 0; i < BIG_N; i++) begin
      if (noise_select_i[BIG_N-1-i]) begin
        sum_c = W'(sum_c + publickey_i[i*W +: W]);
      end
    end
    ciphertext_d = sum_c;
    if (row_i == '0) begin
      ciphertext_d = W'(sum_c + W'(plaintext_i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ciphertext_q <= '0;
    end else begin
      ciphertext_q <= ciphertext_d;
    end
  end

  assign ciphertext_o = ciphertext_q;

endmodule

// File: rtl/lwe_encrypt_multiply.sv
// LWE encrypt engine plus streaming ciphertext polynomial multiplier.
//   enc_*                 : encrypt engine inputs, enc_ciphertext registered out
//   mul_ciphertext_entry  : streamed operand entry
//   mul_row               : entry / coefficient index
//   mul_ciphertext_select : 0 = ct1 (stored), 1 = ct2 (multiplied in)
//   mul_en                : input valid; all multiply state holds when low
//   mul_result_partial    : registered product coefficient
module lwe_encrypt_multiply
  import lwe_pkg::*;
(
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [PLAINTEXT_WIDTH-1:0]        enc_plaintext,
  input  logic [BIG_N*CIPHERTEXT_WIDTH-1:0] enc_publickey_row,
  input  logic [BIG_N-1:0]                  enc_noise_select,
  input  logic [ROW_WIDTH-1:0]              enc_row,
  output logic [CIPHERTEXT_WIDTH-1:0]       enc_ciphertext,
  input  logic [CIPHERTEXT_WIDTH-1:0]       mul_ciphertext_entry,
  input  logic [ROW_WIDTH-1:0]              mul_row,
  input  logic                              mul_ciphertext_select,
  input  logic                              mul_en,
  output logic [CIPHERTEXT_WIDTH-1:0]       mul_result_partial
);

  lwe_encrypt_row #(
    .BIG_N (BIG_N),
    .W     (CIPHERTEXT_WIDTH),
    .PT_W  (PLAINTEXT_WIDTH),
    .ROW_W (ROW_WIDTH)
  ) u_encrypt_row (
    .clk            (clk),
    .rst_n          (rst_n),
    .plaintext_i    (enc_plaintext),
    .publickey_i    (enc_publickey_row),
    .noise_select_i (enc_noise_select),
    .row_i          (enc_row),
    .ciphertext_o   (enc_ciphertext)
  );

  logic [CT_ROWS-1:0][CIPHERTEXT_WIDTH-1:0]  ct1_q, ct1_d;
  logic [ACC_ROWS-1:0][CIPHERTEXT_WIDTH-1:0] acc_q, acc_d;
  logic [CIPHERTEXT_WIDTH-1:0]               res_q, res_d;

  logic row_in_ct_c;
  logic row_in_acc_c;

  assign row_in_ct_c  = (mul_row <= ROW_WIDTH'(DIMENSION));
  assign row_in_acc_c = (mul_row <= ROW_WIDTH'(2 * DIMENSION));

  // Multiply engine next state. Coefficient j is final once ct2[j] is folded
  // in, because later ct2 entries only touch higher coefficients.
  always_comb begin
    ct1_d = ct1_q;
    acc_d = acc_q;
    res_d = res_q;
    if (mul_en) begin
      res_d = '0;
      if (!mul_ciphertext_select && row_in_ct_c) begin
        for (int unsigned k = 0; k < CT_ROWS; k++) begin
          if (mul_row == ROW_WIDTH'(k)) begin
            ct1_d[k] = mul_ciphertext_entry;
          end
        end
        // Row 0 of ct1 opens a new product.
        if (mul_row == '0) begin
          acc_d = '0;
        end
      end else if (mul_ciphertext_select && row_in_ct_c) begin
        for (int unsigned j = 0; j < CT_ROWS; j++) begin
          if (mul_row == ROW_WIDTH'(j)) begin
            for (int unsigned i = 0; i < CT_ROWS; i++) begin
              acc_d[i+j] = mod_add(acc_q[i+j], mod_mul(ct1_q[i], mul_ciphertext_entry));
            end
            res_d = acc_d[j];
          end
        end
      end else if (!mul_ciphertext_select && row_in_acc_c) begin
        // Upper coefficients are read out without storing anything.
        for (int unsigned k = 0; k < ACC_ROWS; k++) begin
          if (mul_row == ROW_WIDTH'(k)) begin
            res_d = acc_q[k];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ct1_q <= '0;
      acc_q <= '0;
      res_q <= '0;
    end else begin
      ct1_q <= ct1_d;
      acc_q <= acc_d;
      res_q <= res_d;
    end
  end

  assign mul_result_partial = res_q;

endmodule

// File: tb/tb_lwe_encrypt_multiply.sv
// Directed bench for lwe_encrypt_multiply with an expectation queue.
module tb_lwe_encrypt_multiply;
  import lwe_pkg::*;

  localparam int unsigned W  = CIPHERTEXT_WIDTH;
  localparam int unsigned N  = BIG_N;
  localparam int unsigned PW = PLAINTEXT_WIDTH;
  localparam int unsigned RW = ROW_WIDTH;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [PW-1:0] enc_plaintext = '0;
  logic [N*W-1:0] enc_publickey_row = '0;
  logic [N-1:0]  enc_noise_select = '0;
  logic [RW-1:0] enc_row = '0;
  logic [W-1:0]  enc_ciphertext;
  logic [W-1:0]  mul_ciphertext_entry = '0;
  logic [RW-1:0] mul_row = '0;
  logic          mul_ciphertext_select = 1'b0;
  logic          mul_en = 1'b0;
  logic [W-1:0]  mul_result_partial;

  lwe_encrypt_multiply dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .enc_plaintext         (enc_plaintext),
    .enc_publickey_row     (enc_publickey_row),
    .enc_noise_select      (enc_noise_select),
    .enc_row               (enc_row),
    .enc_ciphertext        (enc_ciphertext),
    .mul_ciphertext_entry  (mul_ciphertext_entry),
    .mul_row               (mul_row),
    .mul_ciphertext_select (mul_ciphertext_select),
    .mul_en                (mul_en),
    .mul_result_partial    (mul_result_partial)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        tag;
    bit           is_mul;
    logic [W-1:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int unsigned pk [N];

  task automatic expect_out(input string tag, input bit is_mul, input logic [W-1:0] val);
    exp_t e;
    e.tag = tag;
    e.is_mul = is_mul;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check_outputs();
    exp_t e;
    logic [W-1:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      obs = e.is_mul ? mul_result_partial : enc_ciphertext;
      checks++;
      assert (obs === e.val) else begin
        failures++;
        $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  function automatic logic [N*W-1:0] pack(input int unsigned p [N]);
    logic [N*W-1:0] v;
    v = '0;
    for (int i = 0; i < int'(N); i++) v[i*W +: W] = W'(p[i]);
    return v;
  endfunction

  function automatic logic [W-1:0] enc_model(input int unsigned p [N], input logic [N-1:0] noise,
                                             input int unsigned pt, input int unsigned row);
    int unsigned s;
    s = 0;
    for (int i = 0; i < int'(N); i++) if (noise[N-1-i]) s += p[i];
    if (row == 0) s += pt;
    return W'(s % CIPHERTEXT_MODULUS);
  endfunction

  task automatic enc_drive(input logic [N-1:0] noise, input int unsigned pt, input int unsigned row);
    enc_publickey_row = pack(pk);
    enc_noise_select = noise;
    enc_plaintext = PW'(pt);
    enc_row = RW'(row);
  endtask

  task automatic mul_drive(input bit sel, input int unsigned row, input int unsigned entry);
    mul_en = 1'b1;
    mul_ciphertext_select = sel;
    mul_row = RW'(row);
    mul_ciphertext_entry = W'(entry);
  endtask

  // Full ct1 then ct2 stream; coefficients come from the convolution c[k] = sum a[i]*b[k-i].
  task automatic run_stream(input int unsigned a0, input int unsigned a1,
                            input int unsigned b0, input int unsigned b1, input bit hold);
    logic [W-1:0] c [3];
    c[0] = W'(a0 * b0);
    c[1] = W'(a0 * b1 + a1 * b0);
    c[2] = W'(a1 * b1);
    mul_drive(1'b0, 0, a0); expect_out("mul_ct1_row0", 1'b1, '0); step();
    mul_drive(1'b0, 1, a1); expect_out("mul_ct1_row1", 1'b1, '0); step();
    mul_drive(1'b1, 0, b0); expect_out("mul_coef0", 1'b1, c[0]); step();
    if (hold) begin
      for (int k = 0; k < 3; k++) begin
        mul_en = 1'b0;
        mul_ciphertext_select = 1'b1;
        mul_row = RW'(1);
        mul_ciphertext_entry = W'($urandom);
        expect_out("mul_hold", 1'b1, c[0]);
        step();
      end
    end
    mul_drive(1'b1, 1, b1); expect_out("mul_coef1", 1'b1, c[1]); step();
    mul_drive(1'b0, 2, 0);  expect_out("mul_coef2", 1'b1, c[2]); step();
    mul_en = 1'b0;
  endtask

  initial begin
    // Reset state
    #1 rst_n = 1'b0;
    #2;
    expect_out("reset_enc", 1'b0, '0);
    expect_out("reset_mul", 1'b1, '0);
    check_outputs();
    #9 rst_n = 1'b1;

    // Encrypt engine
    pk = '{56, 8, 24, 16, 56};
    enc_drive(5'b10111, 2, 0); expect_out("enc_row0_sum", 1'b0, W'(26)); step();
    enc_drive(5'b00000, 3, 0); expect_out("enc_noise0_row0", 1'b0, W'(3)); step();
    enc_drive(5'b00000, 3, 1); expect_out("enc_noise0_row1", 1'b0, W'(0)); step();
    pk = '{1, 48, 45, 48, 54};
    enc_drive(5'b10111, 2, 1); expect_out("enc_row1_sum", 1'b0, W'(20)); step();
    pk = '{63, 63, 63, 63, 63};
    enc_drive(5'b11111, 7, 0); expect_out("enc_all_wrap", 1'b0, W'(2)); step();
    pk = '{0, 0, 0, 0, 9};
    enc_drive(5'b00001, 0, 0); expect_out("enc_lsb_sel_last", 1'b0, W'(9)); step();
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < int'(N); i++) pk[i] = $urandom_range(0, CIPHERTEXT_MODULUS - 1);
      enc_drive(N'($urandom), $urandom_range(0, PLAINTEXT_MODULUS - 1), r % 2);
      expect_out("enc_random", 1'b0, enc_model(pk, enc_noise_select, enc_plaintext, enc_row));
      step();
    end

    // Multiply engine: plain stream, then the same stream with a stall
    run_stream(26, 20, 3, 0, 1'b0);
    run_stream(26, 20, 3, 0, 1'b1);

    // Reset mid-stream
    mul_drive(1'b0, 0, 26); expect_out("mul_pre_rst_ct1_0", 1'b1, '0); step();
    mul_drive(1'b0, 1, 20); expect_out("mul_pre_rst_ct1_1", 1'b1, '0); step();
    mul_drive(1'b1, 0, 3);  expect_out("mul_pre_rst_coef0", 1'b1, W'(14)); step();
    #2 rst_n = 1'b0;
    #1;
    expect_out("async_rst_mul", 1'b1, '0);
    expect_out("async_rst_enc", 1'b0, '0);
    check_outputs();
    mul_en = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    // ct1 store was cleared, so a lone ct2 entry multiplies by zero.
    mul_drive(1'b1, 0, 5); expect_out("mul_ct1_cleared", 1'b1, '0); step();
    run_stream(63, 5, 7, 9, 1'b0);

    // Ignored combinations must not disturb the accumulators
    mul_drive(1'b1, 2, 11); expect_out("mul_sel1_row2_ignored", 1'b1, '0); step();
    mul_drive(1'b0, 3, 11); expect_out("mul_row3_ignored", 1'b1, '0); step();
    mul_drive(1'b0, 2, 0);  expect_out("mul_coef2_reread", 1'b1, W'(45)); step();
    mul_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lwe_encrypt_multiply.md
Name: lwe_encrypt_multiply

Overview:
- Small LWE-style homomorphic-encryption datapath with two independent engines sharing one clock and reset.
- The encrypt engine produces one ciphertext entry per cycle. It sums a subset of public-key entries, selected by noise bits, and adds the plaintext on row 0.
- The multiply engine streams two ciphertext vectors in one entry at a time. It emits their polynomial (convolution) product one coefficient per cycle, all modulo CIPHERTEXT_MODULUS.

Parameters:
- PLAINTEXT_MODULUS, 8, plaintext modulus (power of two).
- PLAINTEXT_WIDTH, 3, log2(PLAINTEXT_MODULUS).
- CIPHERTEXT_MODULUS, 64, ciphertext modulus q (power of two).
- CIPHERTEXT_WIDTH, 6, log2(q); W below.
- DIMENSION, 1, LWE dimension D; a ciphertext has D+1 entries.
- BIG_N, 5, number of public-key entries per row.

Ports:
- clk, in, 1, single clock, rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- enc_plaintext, in, PLAINTEXT_WIDTH, message to encrypt.
- enc_publickey_row, in, BIG_N*W, flattened public-key column; entry i is bits [i*W +: W].
- enc_noise_select, in, BIG_N, subset-selection bits.
- enc_row, in, D+1, ciphertext entry index being produced.
- enc_ciphertext, out, W, registered ciphertext entry.
- mul_ciphertext_entry, in, W, incoming ciphertext entry.
- mul_row, in, D+1, entry index (0..2D).
- mul_ciphertext_select, in, 1, 0 = first operand (ct1), 1 = second operand (ct2).
- mul_en, in, 1, input-valid strobe.
- mul_result_partial, out, W, registered product coefficient.

Behaviour:
Reset:
- rst_n low asynchronously clears enc_ciphertext, mul_result_partial, the ct1 store and all accumulators to 0.
- Reset mid-stream discards partial products.

Arithmetic:
- All arithmetic is unsigned modulo 2^W; carries are dropped.

Encrypt engine (1-cycle latency, updates every cycle):
- Sum = Σ pk[i] over i = 0..BIG_N-1 where enc_noise_select[BIG_N-1-i] = 1. Note the MSB of noise_select selects pk[0].
- enc_ciphertext <= Sum + (enc_row == 0 ? zero-extended enc_plaintext : 0).
- Plaintext is added unscaled.
- noise_select = 0 yields the plaintext on row 0 and 0 on other rows.

Multiply engine (acts only when mul_en = 1; when mul_en = 0 all state and output hold):
- sel = 0, row ≤ D:
  - store ct1[row] <= entry;
  - row 0 also clears all 2D+1 accumulators;
  - mul_result_partial <= 0.
- sel = 1, row = j ≤ D:
  - for every i in 0..D, acc[i+j] += ct1[i]*entry;
  - mul_result_partial <= the updated acc[j] in the same edge. It is final because ct2 entries arrive in ascending order.
- sel = 0, D < row ≤ 2D: mul_result_partial <= acc[row]; no storage.
- sel = 1, row > D, or any row > 2D: ignored; output <= 0.
- Latency: 1 cycle from capture edge to output.
- ct2 must be sent in ascending row order after all ct1 rows. Out-of-order streams give undefined coefficients, not a hang.

Decomposition:
- Package lwe_pkg holds the default parameter constants and a helper function for the modular add/multiply width.
- Sub-module lwe_encrypt_row is the encrypt engine. The top instantiates it beside the inline multiply engine.

Test Plan:
1. Encrypt row 0: pk = {56,8,24,16,56}, noise = 5'b10111, pt = 2 -> enc_ciphertext = 26 one cycle later. Selected sum is 24 (152 mod 64), plus 2.
2. Encrypt row 0, pt = 3, noise = 0 -> 3; same inputs with row 1 -> 0.
3. Encrypt row 1: pk = {1,48,45,48,54}, noise = 5'b10111, pt = 2 -> 20 (148 mod 64).
4. Multiply:
   - ct1 = (26,20) with sel 0, rows 0,1; then ct2 = (3,0) with sel 1;
   - outputs 14 after ct2[0] (78 mod 64) and 60 after ct2[1];
   - then sel 0, row 2 -> 0.
5. mul_en low for 3 cycles mid-stream -> output and accumulators hold; resuming gives the same results as test 4.
6. Assert rst_n mid-stream -> outputs go to 0 immediately without a clock edge; a fresh stream after release yields correct results.
